// File: rtl/rx_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rx_seq_pkg
// Description : Shared types, widths and helpers for the RX sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_seq_pkg;

    localparam int RATE_W           = 12;
    localparam int RX_DATA_W        = 64;
    localparam int RATE_MIN_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        FLUSH = 3'd2,
        ACQ   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [RATE_W-1:0] clamp_rate(
        input logic [RATE_W-1:0] rate,
        input logic [RATE_W-1:0] rate_min
    );
        return (rate < rate_min) ? rate_min : rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_seq_ctrl_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : rx_out_reg
// Description : One-entry AXI-stream output register; flags samples that
//               arrive while it is full and not draining.
// Options     : RX_TLAST_EN adds a registered tlast bit
// Revision    : 1.0 - initial release
// ============================================================================
module rx_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tready,
    output logic              o_tvalid,
    output logic [DATA_W-1:0] o_tdata,
`ifdef RX_TLAST_EN
    input  logic              i_last,
    output logic              o_tlast,
`endif
    output logic              o_drop
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_load;

    assign w_load = i_valid & (~r_valid | i_tready);
    assign o_drop = i_valid & r_valid & ~i_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef RX_TLAST_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (w_load) begin
            r_last <= i_last;
        end
    end

    assign o_tlast = r_last & r_valid;
`endif

    assign o_tvalid = r_valid;
    assign o_tdata  = r_data;

endmodule
`default_nettype wire

// File: rtl/rx_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_seq_ctrl
// Description : Sequencer for one RX decimation chain: programs the rate,
//               flushes the chain, then gates N samples downstream.
// Options     : RX_TLAST_EN adds out_tlast_o on the final sample beat
// Revision    : 1.0 - initial release
// ============================================================================
module rx_seq_ctrl
    import rx_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES = 8,
    parameter int RATE_MIN     = RATE_MIN_DEFAULT,
    parameter int NSAMP_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [RATE_W-1:0]    cmd_rate_i,
    input  logic [NSAMP_W-1:0]   cmd_nsamp_i,
    input  logic                 abort_i,
    output logic [15:0]          rate_axis_tdata_o,
    output logic                 rate_axis_tvalid_o,
    input  logic                 rate_axis_tready_i,
    output logic                 chain_rst_n_o,
    input  logic                 rx_tvalid_i,
    input  logic [RX_DATA_W-1:0] rx_tdata_i,
    output logic                 rx_tready_o,
    output logic                 out_tvalid_o,
    output logic [RX_DATA_W-1:0] out_tdata_o,
    input  logic                 out_tready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
`ifdef RX_TLAST_EN
    output logic                 out_tlast_o,
`endif
    output logic [NSAMP_W-1:0]   sample_cnt_o
);

    localparam logic [RATE_W-1:0] C_RATE_MIN   = RATE_W'(RATE_MIN);
    localparam logic [7:0]        C_FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

    state_t               r_state;
    logic [RATE_W-1:0]    r_rate;
    logic [NSAMP_W-1:0]   r_nsamp;
    logic [NSAMP_W-1:0]   r_sample_cnt;
    logic [7:0]           r_flush_cnt;
    logic                 r_overflow;
    logic                 r_cmd_ready;
    logic                 r_rate_tvalid;
    logic                 r_chain_rst_n;
    logic                 r_rx_tready;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_cmd_acc;
    logic                 w_rx_acc;
    logic [NSAMP_W-1:0]   w_cnt_next;
    logic                 w_last_sample;
    logic                 w_drop;
    logic                 w_go_idle;

    assign w_cmd_acc     = cmd_valid_i & r_cmd_ready;
    assign w_rx_acc      = rx_tvalid_i & r_rx_tready;
    assign w_cnt_next    = r_sample_cnt + 1'b1;
    assign w_last_sample = (w_cnt_next == r_nsamp);

    // DONE always returns to IDLE; abort only matters while the chain is in use.
    always_comb begin
        w_go_idle = 1'b0;
        case (r_state)
            IDLE:             w_go_idle = 1'b0;
            CFG, FLUSH, ACQ:  w_go_idle = abort_i;
            default:          w_go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rate        <= '0;
            r_nsamp       <= '0;
            r_sample_cnt  <= '0;
            r_flush_cnt   <= '0;
            r_overflow    <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rate_tvalid <= 1'b0;
            r_chain_rst_n <= 1'b0;
            r_rx_tready   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // Dropped samples still count: acquisition length is time-based.
            if (w_rx_acc && (r_sample_cnt != r_nsamp)) begin
                r_sample_cnt <= w_cnt_next;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_go_idle) begin
                r_state       <= IDLE;
                r_cmd_ready   <= 1'b1;
                r_rate_tvalid <= 1'b0;
                r_chain_rst_n <= 1'b0;
                r_rx_tready   <= 1'b0;
                r_busy        <= 1'b0;
                r_done        <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cmd_acc) begin
                            r_rate        <= clamp_rate(cmd_rate_i, C_RATE_MIN);
                            r_nsamp       <= cmd_nsamp_i;
                            r_sample_cnt  <= '0;
                            r_overflow    <= 1'b0;
                            r_state       <= CFG;
                            r_cmd_ready   <= 1'b0;
                            r_busy        <= 1'b1;
                            r_rate_tvalid <= 1'b1;
                        end
                    end
                    CFG: begin
                        if (rate_axis_tready_i) begin
                            r_state       <= FLUSH;
                            r_rate_tvalid <= 1'b0;
                            r_flush_cnt   <= C_FLUSH_LOAD;
                        end
                    end
                    FLUSH: begin
                        if (r_flush_cnt == 8'd0) begin
                            if (r_nsamp == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state       <= ACQ;
                                r_chain_rst_n <= 1'b1;
                                r_rx_tready   <= 1'b1;
                            end
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 8'd1;
                        end
                    end
                    ACQ: begin
                        if (w_rx_acc && w_last_sample) begin
                            r_state       <= DONE;
                            r_done        <= 1'b1;
                            r_chain_rst_n <= 1'b0;
                            r_rx_tready   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    rx_out_reg #(
        .DATA_W   (RX_DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (w_rx_acc),
        .i_data   (rx_tdata_i),
        .i_tready (out_tready_i),
        .o_tvalid (out_tvalid_o),
        .o_tdata  (out_tdata_o),
`ifdef RX_TLAST_EN
        .i_last   (w_last_sample),
        .o_tlast  (out_tlast_o),
`endif
        .o_drop   (w_drop)
    );

    assign cmd_ready_o        = r_cmd_ready;
    assign rate_axis_tdata_o  = {4'b0000, r_rate};
    assign rate_axis_tvalid_o = r_rate_tvalid;
    assign chain_rst_n_o      = r_chain_rst_n;
    assign rx_tready_o        = r_rx_tready;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign overflow_o         = r_overflow;
    assign sample_cnt_o       = r_sample_cnt;

endmodule
`default_nettype wire

// File: doc/rx_seq_ctrl.md
Name: rx_seq_ctrl

Overview:
Sequencer for one RX decimation chain. Accepts acquisition commands (decimation rate, sample count) and programs the chain's rate AXI-stream. It then flushes the chain by holding it in reset and gates exactly N output samples through a one-entry AXI-stream output register to the downstream buffer. Sits between the sequencer/command FIFO and the RX chain output, and reports done/overflow status.

Parameters:
FLUSH_CYCLES, 8, cycles chain_rst_n_o is held low before each acquisition (1..255)
RATE_MIN, 4, minimum decimation rate; smaller commanded rates are clamped up to this value
NSAMP_W, 16, width of the sample-count field and counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready; high only in IDLE
cmd_rate_i  in  12  decimation rate for the acquisition
cmd_nsamp_i  in  NSAMP_W  number of samples to acquire
abort_i  in  1  abort the current acquisition
rate_axis_tdata_o  out  16  {4'b0, clamped rate} to the chain
rate_axis_tvalid_o  out  1  rate word valid
rate_axis_tready_i  in  1  rate word accepted
chain_rst_n_o  out  1  active-low reset to the chain
rx_tvalid_i  in  1  chain sample valid
rx_tdata_i  in  64  chain sample {I/Q ch1, I/Q ch0}
rx_tready_o  out  1  high in ACQ only
out_tvalid_o  out  1  downstream sample valid
out_tdata_o  out  64  downstream sample
out_tready_i  in  1  downstream ready
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when an acquisition completes
overflow_o  out  1  sticky; set when a sample is dropped, cleared on command accept
sample_cnt_o  out  NSAMP_W  samples taken in the current/last acquisition

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0 except cmd_ready_o=1 and chain_rst_n_o=0 (chain is held in reset while idle). out_tdata_o=0. Command registers cleared.
- IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch rate_q = max(cmd_rate_i, RATE_MIN) and nsamp_q, clear overflow_o and sample_cnt_o, then go to CFG.
- CFG: rate_axis_tvalid_o=1 and rate_axis_tdata_o stable until rate_axis_tready_i. In the handshake cycle go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
- FLUSH: chain_rst_n_o=0; count down. At 0, go to ACQ; if nsamp_q==0, go directly to DONE instead.
- ACQ: chain_rst_n_o=1, rx_tready_o=1. Each rx_tvalid_i increments sample_cnt_o.
  - The sample loads the output register if it is empty or being drained this cycle (out_tready_i=1).
  - Otherwise the sample is dropped, overflow_o is set, and it still counts (acquisition is time-based).
  - When sample_cnt_o reaches nsamp_q, go to DONE.
- DONE: done_o=1 for exactly one cycle, chain_rst_n_o=0, then IDLE.
- Sample latency: rx accept edge to out_tvalid_o high = 1 cycle. The output register obeys AXIS rules: once out_tvalid_o rises, tdata is held stable and tvalid stays high until accepted, in every state including IDLE and after abort.
- abort_i: in CFG/FLUSH/ACQ, go to IDLE next cycle with no done_o. Chain reset is asserted; a pending out beat is retained. abort_i is ignored in IDLE and DONE.
- Samples presented outside ACQ are ignored (rx_tready_o=0).
- sample_cnt_o saturates at nsamp_q and does not wrap.
- A cmd_valid_i arriving while busy is not accepted; it waits.

Optional Feature:
RX_TLAST_EN: when defined, add port out_tlast_o (out, 1). It is registered with the data and high on the beat carrying sample index nsamp_q-1. If that beat is dropped, no tlast is emitted and overflow_o flags it. When undefined, the port is absent and no tlast logic is built.

Decomposition:
- Package rx_seq_pkg: state enum {IDLE, CFG, FLUSH, ACQ, DONE}, RATE_W=12, RX_DATA_W=64, default RATE_MIN.
- Sub-module rx_out_reg: one-entry AXIS output register with a drop/overflow indication (optional tlast bit).

Test Plan:
- Rate 10, nsamp 5, out_tready_i=1 -> rate tdata 0x000A; chain_rst_n_o low 8 cycles; 5 out beats each 1 cycle after rx; done_o one pulse; overflow_o=0.
- Rate 2 -> rate_axis_tdata_o=0x0004 (clamped); rate 0 -> 0x0004.
- nsamp 0 -> CFG, FLUSH, DONE; no rx_tready_o; done_o pulses; zero out beats.
- out_tready_i=0 during 3 rx samples -> first held stable; next 2 dropped; overflow_o=1; sample_cnt_o=3; next command clears overflow_o.
- abort_i mid-ACQ after 2 of 10 samples with one beat pending -> IDLE next cycle; no done_o; pending beat still delivered when out_tready_i rises.
- rate_axis_tready_i low for 4 cycles in CFG -> tvalid/tdata held; FLUSH starts only after handshake. With RX_TLAST_EN, nsamp 3 -> tlast only on 3rd beat.
